// File: rtl/posit_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : posit_fetch_pkg
//  Brief   : Shared state encoding and layout constants for the posit fetcher.
//  Revision: 1.0 - initial release
// ============================================================================
package posit_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } fetch_state_t;

  localparam int BYTES_PER_POSIT  = 4;
  localparam int BYTES_PER_PAIR   = 2 * BYTES_PER_POSIT;
  localparam int MEM_READ_LATENCY = 1;
  localparam int SLOT_W           = $clog2(BYTES_PER_PAIR);

endpackage
`default_nettype wire

// File: rtl/posit_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module  : posit_word_assembler
//  Brief   : Eight byte-slot capture register presenting {num2, num1}.
//  Revision: 1.0 - initial release
// ============================================================================
module posit_word_assembler
  import posit_fetch_pkg::*;
#(
  parameter int BYTE_W  = 8,
  parameter int POSIT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cap_en,
  input  logic [SLOT_W-1:0]  i_cap_slot,
  input  logic [BYTE_W-1:0]  i_cap_data,
  output logic [POSIT_W-1:0] o_num1,
  output logic [POSIT_W-1:0] o_num2
);

  logic [BYTES_PER_PAIR*BYTE_W-1:0] w_bytes;

  // Slot i holds byte i of the pair; slots 0..3 form num1, 4..7 num2, LSB first.
  for (genvar i = 0; i < BYTES_PER_PAIR; i++) begin : g_slot
    logic [BYTE_W-1:0] r_byte;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_byte <= '0;
      end else if (i_cap_en && (i_cap_slot == SLOT_W'(i))) begin
        r_byte <= i_cap_data;
      end
    end

    assign w_bytes[i*BYTE_W +: BYTE_W] = r_byte;
  end

  assign o_num1 = w_bytes[POSIT_W-1:0];
  assign o_num2 = w_bytes[2*POSIT_W-1:POSIT_W];

endmodule
`default_nettype wire

// File: rtl/posit_operand_fetcher.sv
`default_nettype none
// ============================================================================
//  Module  : posit_operand_fetcher
//  Brief   : Walks byte memory from a base address and streams posit pairs.
//  Revision: 1.0 - initial release
// ============================================================================
module posit_operand_fetcher
  import posit_fetch_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int BYTE_W  = 8,
  parameter int POSIT_W = 32,
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_start,
  input  logic [ADDR_W-1:0]  io_base_address,
  input  logic [COUNT_W-1:0] io_pair_count,
  output logic [ADDR_W-1:0]  io_mem_address,
  input  logic [BYTE_W-1:0]  io_mem_readdata,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [POSIT_W-1:0] io_out_num1,
  output logic [POSIT_W-1:0] io_out_num2,
  output logic               io_busy,
  output logic               io_done
);

  fetch_state_t       r_state, w_state_next;
  logic [ADDR_W-1:0]  r_base, w_base_next;
  logic [COUNT_W-1:0] r_count, w_count_next;
  logic [COUNT_W-1:0] r_pair, w_pair_next;
  logic [SLOT_W-1:0]  r_idx, w_idx_next;
  logic               w_cap_en;
  logic [SLOT_W-1:0]  w_cap_slot;
  logic [ADDR_W-1:0]  w_fetch_addr;
  logic               w_last_pair;

  // Address arithmetic deliberately truncates to ADDR_W so fetches wrap.
  assign w_fetch_addr = r_base + ADDR_W'({r_pair, SLOT_W'(0)}) + ADDR_W'(r_idx);
  assign w_last_pair  = (r_pair == r_count - 1'b1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_count <= '0;
      r_pair  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_base  <= w_base_next;
      r_count <= w_count_next;
      r_pair  <= w_pair_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_base_next    = r_base;
    w_count_next   = r_count;
    w_pair_next    = r_pair;
    w_idx_next     = r_idx;
    w_cap_en       = 1'b0;
    w_cap_slot     = r_idx - SLOT_W'(MEM_READ_LATENCY);
    io_mem_address = '0;
    io_out_valid   = 1'b0;
    io_busy        = 1'b0;
    io_done        = (r_state == DONE);

    case (r_state)
      IDLE, DONE: begin
        if (io_start) begin
          w_base_next  = io_base_address;
          w_count_next = io_pair_count;
          w_pair_next  = '0;
          w_idx_next   = '0;
          w_state_next = (io_pair_count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        io_busy        = 1'b1;
        io_mem_address = w_fetch_addr;
        // Data returned this cycle belongs to the address issued one cycle ago.
        w_cap_en       = (r_idx != '0);
        w_idx_next     = r_idx + 1'b1;
        if (r_idx == SLOT_W'(BYTES_PER_PAIR - 1)) begin
          w_state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        io_busy      = 1'b1;
        w_cap_en     = 1'b1;
        w_cap_slot   = SLOT_W'(BYTES_PER_PAIR - 1);
        w_state_next = PRESENT;
      end
      PRESENT: begin
        io_busy      = 1'b1;
        io_out_valid = 1'b1;
        if (io_out_ready) begin
          w_pair_next  = r_pair + 1'b1;
          w_idx_next   = '0;
          w_state_next = w_last_pair ? DONE : FETCH;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  posit_word_assembler #(
    .BYTE_W  (BYTE_W),
    .POSIT_W (POSIT_W)
  ) u_assembler (
    .clk        (clock),
    .rst        (reset),
    .i_cap_en   (w_cap_en),
    .i_cap_slot (w_cap_slot),
    .i_cap_data (io_mem_readdata),
    .o_num1     (io_out_num1),
    .o_num2     (io_out_num2)
  );

endmodule
`default_nettype wire

// File: tb/tb_posit_operand_fetcher.sv
`default_nettype none
// ============================================================================
//  Module  : tb_posit_operand_fetcher
//  Brief   : Directed, table-driven bench for posit_operand_fetcher.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_posit_operand_fetcher;

  logic        clock;
  logic        reset;
  logic        io_start;
  logic [11:0] io_base_address;
  logic [7:0]  io_pair_count;
  logic [11:0] io_mem_address;
  logic [7:0]  io_mem_readdata;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_num1;
  logic [31:0] io_out_num2;
  logic        io_busy;
  logic        io_done;

  logic [7:0] mem [4096];
  int n_vec = 0;
  int n_bad = 0;

  posit_operand_fetcher dut (
    .clock           (clock),
    .reset           (reset),
    .io_start        (io_start),
    .io_base_address (io_base_address),
    .io_pair_count   (io_pair_count),
    .io_mem_address  (io_mem_address),
    .io_mem_readdata (io_mem_readdata),
    .io_out_valid    (io_out_valid),
    .io_out_ready    (io_out_ready),
    .io_out_num1     (io_out_num1),
    .io_out_num2     (io_out_num2),
    .io_busy         (io_busy),
    .io_done         (io_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One-cycle read latency memory.
  always @(posedge clock) io_mem_readdata <= mem[io_mem_address];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [11:0] base;
    logic [31:0] num1;
    logic [31:0] num2;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put_pair(input logic [11:0] a, input logic [31:0] n1, input logic [31:0] n2);
    logic [11:0] p;
    for (int i = 0; i < 4; i++) begin
      p = a + 12'(i);
      mem[p] = n1[8*i +: 8];
      p = a + 12'(i + 4);
      mem[p] = n2[8*i +: 8];
    end
  endtask

  // Called in the launch/handshake cycle; follows one pair through to its handshake.
  task automatic expect_pair(input logic [11:0] a0, input logic [31:0] e1, input logic [31:0] e2,
                             input int hold, input int poke);
    logic [11:0] a;
    io_out_ready = (hold == 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      io_start = (k == poke);
      if (k == poke) begin
        io_base_address = 12'h300;
        io_pair_count   = 8'd0;
      end
      if (k <= 8) begin
        a = a0 + 12'(k - 1);
        check("fetch_addr", io_mem_address, a);
        check("busy_fetch", io_busy, 1);
      end
      if (k < 10) check("valid_early", io_out_valid, 0);
    end
    check("valid_rise", io_out_valid, 1);
    check("num1", io_out_num1, e1);
    check("num2", io_out_num2, e2);
    check("addr_present", io_mem_address, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", io_out_valid, 1);
      check("hold_num1", io_out_num1, e1);
      check("hold_num2", io_out_num2, e2);
      check("hold_addr", io_mem_address, 0);
    end
    io_out_ready = 1'b1;
  endtask

  task automatic expect_done();
    tick();
    check("done", io_done, 1);
    check("busy_done", io_busy, 0);
    check("valid_done", io_out_valid, 0);
    check("addr_done", io_mem_address, 0);
  endtask

  task automatic launch(input logic [11:0] base, input logic [7:0] cnt);
    io_base_address = base;
    io_pair_count   = cnt;
    io_start        = 1'b1;
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{base: 12'h000, num1: 32'h4000_0000, num2: 32'h4000_0000};
    vecs[1] = '{base: 12'hFFC, num1: 32'h3C00_FF01, num2: 32'hDEAD_BEEF};
    vecs[2] = '{base: 12'h123, num1: 32'h8000_0000, num2: 32'h7FFF_FFFF};
    vecs[3] = '{base: 12'hFF9, num1: 32'h0102_0304, num2: 32'hCAFE_F00D};

    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    reset           = 1'b1;
    io_start        = 1'b0;
    io_base_address = '0;
    io_pair_count   = '0;
    io_out_ready    = 1'b0;
    tick();
    tick();
    check("rst_addr", io_mem_address, 0);
    check("rst_valid", io_out_valid, 0);
    check("rst_num1", io_out_num1, 0);
    check("rst_num2", io_out_num2, 0);
    check("rst_busy", io_busy, 0);
    check("rst_done", io_done, 0);
    reset = 1'b0;
    tick();

    // Single-pair vectors, including an address wrap past 0xFFF.
    for (int v = 0; v < 4; v++) begin
      put_pair(vecs[v].base, vecs[v].num1, vecs[v].num2);
      launch(vecs[v].base, 8'd1);
      expect_pair(vecs[v].base, vecs[v].num1, vecs[v].num2, 0, 0);
      expect_done();
      tick();
      check("done_held", io_done, 1);
    end

    // Three consecutive pairs.
    for (int k = 0; k < 3; k++) put_pair(12'h010 + 12'(8 * k), 32'h1122_3344 + k, 32'hA0B0_C0D0 + k);
    launch(12'h010, 8'd3);
    for (int k = 0; k < 3; k++) expect_pair(12'h010 + 12'(8 * k), 32'h1122_3344 + k, 32'hA0B0_C0D0 + k, 0, 0);
    expect_done();

    // Backpressure: five stalled cycles in PRESENT.
    put_pair(12'h040, 32'h5555_AAAA, 32'h0F0F_F0F0);
    launch(12'h040, 8'd1);
    expect_pair(12'h040, 32'h5555_AAAA, 32'h0F0F_F0F0, 5, 0);
    expect_done();

    // Zero-length request finishes immediately with no data.
    launch(12'h080, 8'd0);
    tick();
    io_start = 1'b0;
    check("cnt0_done", io_done, 1);
    check("cnt0_busy", io_busy, 0);
    for (int c = 0; c < 12; c++) begin
      tick();
      check("cnt0_valid", io_out_valid, 0);
      check("cnt0_addr", io_mem_address, 0);
    end

    // Asynchronous reset mid-fetch.
    put_pair(12'h100, 32'h1357_9BDF, 32'h2468_ACE0);
    launch(12'h100, 8'd2);
    for (int c = 1; c <= 5; c++) begin
      tick();
      io_start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("amid_addr", io_mem_address, 0);
    check("amid_valid", io_out_valid, 0);
    check("amid_num1", io_out_num1, 0);
    check("amid_num2", io_out_num2, 0);
    check("amid_busy", io_busy, 0);
    check("amid_done", io_done, 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      check("post_rst_valid", io_out_valid, 0);
      check("post_rst_busy", io_busy, 0);
      check("post_rst_done", io_done, 0);
    end

    // Start pulsed while busy must be ignored.
    put_pair(12'h200, 32'hAAAA_0001, 32'hBBBB_0001);
    put_pair(12'h208, 32'hAAAA_0002, 32'hBBBB_0002);
    put_pair(12'h300, 32'hDEAD_DEAD, 32'hDEAD_DEAD);
    launch(12'h200, 8'd2);
    expect_pair(12'h200, 32'hAAAA_0001, 32'hBBBB_0001, 0, 4);
    expect_pair(12'h208, 32'hAAAA_0002, 32'hBBBB_0002, 0, 0);
    expect_done();

    // Full-range count: the pair counter must reach 255 without early termination.
    for (int k = 0; k < 255; k++) put_pair(12'h800 + 12'(8 * k), 32'h1122_3344 + k, 32'hA0B0_C0D0 + k);
    launch(12'h800, 8'd255);
    for (int k = 0; k < 255; k++) expect_pair(12'h800 + 12'(8 * k), 32'h1122_3344 + k, 32'hA0B0_C0D0 + k, 0, 0);
    expect_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
